fifo_1clk_regs_flags: RTL and testbench
=======================================

Name: fifo_1clk_regs_flags

Overview:
Synchronous single-clock FIFO built from a shift-register array, first-word-fall-through (head word always visible on rd_data). It extends the basic register FIFO with guarded push/pop, a synchronous flush, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It is intended for small elastic buffers (Depth ≤ 32) in stream pipelines where BRAM is wasteful.

Parameters:
Width, 8, data word width in bits (≥1)
Depth, 4, number of entries (≥2)
AfullLevel, Depth-1, almost_full asserted when used ≥ AfullLevel (1..Depth)
AemptyLevel, 1, almost_empty asserted when used ≤ AemptyLevel (0..Depth-1)
UsedBits (localparam), clog2(Depth+1), width of the occupancy count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  synchronous flush; same effect as rst on count, flags and peak
wr_en  in  1  push request
wr_data  in  Width  push data
full  out  1  used == Depth
almost_full  out  1  used ≥ AfullLevel
rd_en  in  1  pop request
rd_data  out  Width  head entry (slot 0); valid when !empty
empty  out  1  used == 0
almost_empty  out  1  used ≤ AemptyLevel
used  out  UsedBits  current occupancy, 0..Depth
overflow  out  1  sticky: push attempted while full with no pop accepted
underflow  out  1  sticky: pop attempted while empty
err_clr  in  1  clears overflow/underflow
peak  out  UsedBits  high-water mark (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): used=0, overflow=0, underflow=0, peak=0; data array not reset. Hence empty=1, full=0, almost_empty=1, almost_full=(AfullLevel==0 ? 1 : 0) = 0.
- rst overrides clr, err_clr, wr_en and rd_en in the same cycle.
- clr=1: used=0, peak=0, overflow/underflow cleared; wr_en/rd_en ignored that cycle.
- Flags full/empty/almost_* are combinational from the used register: zero-cycle latency after the count updates.
- Pop accepted: rd_acc = rd_en & !empty. On accept, slots shift down by one (slot i ← slot i+1); used decrements.
- Push accepted: wr_acc = wr_en & (!full | rd_acc). Data is written to slot (used − rd_acc); used increments.
- Simultaneous accepted push+pop: used unchanged; the new word lands in slot used−1 after the shift. At full, push+pop are both accepted. At empty, push+pop → pop rejected (underflow set), push accepted, used=1.
- Rejected push (wr_en & full & !rd_acc): no state change to data/used; overflow←1 next cycle.
- Rejected pop (rd_en & empty): no change; underflow←1 next cycle.
- Sticky flags hold until err_clr, clr or rst. If err_clr coincides with a new error event, the new event wins (flag stays 1).
- Read latency: a word pushed into an empty FIFO appears on rd_data, with empty=0, the cycle after the push edge.
- rd_data is don't-care while empty; the bench must not check it then.
- used never exceeds Depth and never wraps below 0.

Optional Feature:
Macro FIFO_REGS_PEAK_EN.
- Defined: peak register tracks max(used) since last rst/clr. Updated each cycle to max(peak, next used), so peak equals used in the same cycle as a new maximum is reached.
- Undefined: port peak remains present, tied to 0; no register inferred.

Test Plan:
- Reset, then fill: Depth=4, push 0x11,0x22,0x33,0x44 on consecutive cycles → used 1..4, full=1 after the 4th push, almost_full=1 from used=3, rd_data=0x11 throughout.
- Overflow: at full, push 0x55 with rd_en=0 → used stays 4, overflow=1 next cycle. Then drain all 4 → rd_data sequence 0x11,0x22,0x33,0x44; 0x55 never appears.
- Full push+pop: at full, assert wr_en=1 (0x66) and rd_en=1 together → used stays 4, head advances, and 0x66 is the last word out.
- Empty push+pop: at empty, wr_en=1 (0x77) and rd_en=1 → underflow=1, used=1, rd_data=0x77.
- Flush and err_clr: at used=3 with both sticky flags set, pulse clr → used=0, empty=1, flags=0, peak=0. Separately, err_clr alone clears the flags without changing used.
- Peak (FIFO_REGS_PEAK_EN defined): push 3, pop 2, push 1 → peak=3, used=2. With the macro undefined, peak=0 always.

Source files
------------

// File: rtl/fifo_1clk_regs_flags.sv
// ---------------------------------------------------------------------------
// fifo_1clk_regs_flags
//
// Single-clock, first-word-fall-through FIFO built from a shift-register
// array. The head word (slot 0) is always presented on rd_data. Pops shift
// the array down by one slot. Pushes write at the first free slot, which
// accounts for a pop happening in the same cycle.
//
// Optional feature (macro FIFO_REGS_PEAK_EN):
//   defined   - peak tracks the high-water mark of used since the last rst/clr
//   undefined - peak is tied to 0 and no register is built
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (count, flags, peak)
//   clr          in   synchronous flush, same effect as rst on control state
//   wr_en        in   push request
//   wr_data      in   push data [Width]
//   full         out  used == Depth
//   almost_full  out  used >= AfullLevel
//   rd_en        in   pop request
//   rd_data      out  head entry, valid when !empty [Width]
//   empty        out  used == 0
//   almost_empty out  used <= AemptyLevel
//   used         out  occupancy 0..Depth [UsedBits]
//   overflow     out  sticky, push rejected because full
//   underflow    out  sticky, pop rejected because empty
//   err_clr      in   clears overflow/underflow
//   peak         out  high-water mark [UsedBits]
// ---------------------------------------------------------------------------
module fifo_1clk_regs_flags #(
    parameter int Width       = 8,
    parameter int Depth       = 4,
    parameter int AfullLevel  = Depth - 1,
    parameter int AemptyLevel = 1,
    localparam int UsedBits   = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [Width-1:0]    wr_data,
    output logic                full,
    output logic                almost_full,
    input  logic                rd_en,
    output logic [Width-1:0]    rd_data,
    output logic                empty,
    output logic                almost_empty,
    output logic [UsedBits-1:0] used,
    output logic                overflow,
    output logic                underflow,
    input  logic                err_clr,
    output logic [UsedBits-1:0] peak
);

    localparam logic [UsedBits-1:0] DepthU  = UsedBits'(Depth);
    localparam logic [UsedBits-1:0] AfullU  = UsedBits'(AfullLevel);
    localparam logic [UsedBits-1:0] AemptyU = UsedBits'(AemptyLevel);

    logic [Width-1:0]    mem_q [Depth];
    logic [Width-1:0]    mem_d [Depth];
    logic [UsedBits-1:0] used_q, used_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                flush;
    logic                rd_acc;
    logic                wr_acc;
    logic [UsedBits-1:0] wr_idx;

    // Flags decode straight from the count register.
    assign full         = (used_q == DepthU);
    assign empty        = (used_q == '0);
    assign almost_full  = (used_q >= AfullU);
    assign almost_empty = (used_q <= AemptyU);
    assign used         = used_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign rd_data      = mem_q[0];

    // rst and clr both suppress any push/pop in their cycle.
    assign flush  = rst | clr;
    assign rd_acc = rd_en & ~empty & ~flush;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign wr_acc = wr_en & (~full | rd_acc) & ~flush;
    // Slot index is taken after the shift, hence the rd_acc correction.
    assign wr_idx = used_q - UsedBits'(rd_acc);

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (rd_acc) begin
            for (int i = 0; i < Depth - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (wr_acc) begin
            for (int i = 0; i < Depth; i++) begin
                if (UsedBits'(i) == wr_idx) begin
                    mem_d[i] = wr_data;
                end
            end
        end
    end

    always_comb begin
        used_d = used_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (flush) begin
            used_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            used_d = used_q + UsedBits'(wr_acc) - UsedBits'(rd_acc);
            // A fresh error event takes priority over err_clr.
            if (wr_en & full & ~rd_acc) begin
                ovf_d = 1'b1;
            end else if (err_clr) begin
                ovf_d = 1'b0;
            end
            if (rd_en & empty) begin
                udf_d = 1'b1;
            end else if (err_clr) begin
                udf_d = 1'b0;
            end
        end
    end

    // Storage is never reset; contents are don't-care while unused.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            used_q <= used_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

`ifdef FIFO_REGS_PEAK_EN
    logic [UsedBits-1:0] peak_q, peak_d;

    // Compared against the next count so peak rises on the same edge as used.
    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (used_d > peak_q) begin
            peak_d = used_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_fifo_1clk_regs_flags.sv
// ---------------------------------------------------------------------------
// Testbench for fifo_1clk_regs_flags (Width=8, Depth=4, default levels).
// A queue-based reference model holds the FIFO contents and error flags;
// every cycle all DUT outputs are compared against it on the falling edge.
// Directed scenarios are followed by a biased random run.
// ---------------------------------------------------------------------------
module tb_fifo_1clk_regs_flags;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int UB = $clog2(D + 1);
    localparam int AF = D - 1;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst, clr, wr_en, rd_en, err_clr;
    logic [W-1:0]  wr_data;
    logic          full, almost_full, empty, almost_empty, overflow, underflow;
    logic [W-1:0]  rd_data;
    logic [UB-1:0] used, peak;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    bit           m_ovf, m_udf;
    int           m_peak;

    fifo_1clk_regs_flags #(.Width(W), .Depth(D)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .almost_empty(almost_empty),
        .used(used), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr), .peak(peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("used", 32'(used), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == D));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef FIFO_REGS_PEAK_EN
        chk("peak", 32'(peak), 32'(m_peak));
`else
        chk("peak", 32'(peak), 32'd0);
`endif
        if (n > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    task automatic model_update(input bit r, input bit c, input bit we, input logic [W-1:0] wd,
                                input bit re, input bit ec);
        bit rd_ok, wr_ok, new_ovf, new_udf;
        int n;
        if (r || c) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_peak = 0;
            return;
        end
        n       = mq.size();
        rd_ok   = re && (n > 0);
        wr_ok   = we && ((n < D) || rd_ok);
        new_ovf = we && (n == D) && !rd_ok;
        new_udf = re && (n == 0);
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(wd);
        m_ovf = new_ovf ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_udf = new_udf ? 1'b1 : (ec ? 1'b0 : m_udf);
        if (mq.size() > m_peak) m_peak = mq.size();
    endtask

    // Called on a falling edge: check current state, apply inputs, advance one cycle.
    task automatic step(input bit r, input bit c, input bit we, input logic [W-1:0] wd,
                        input bit re, input bit ec);
        check_model();
        rst = r; clr = c; wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
        model_update(r, c, we, wd, re, ec);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] d);
        step(0, 0, 1, d, 0, 0);
    endtask

    task automatic pop();
        step(0, 0, 0, 8'h00, 1, 0);
    endtask

    initial begin
        logic [W-1:0] exp_seq [4];
        int bias_w, bias_r;

        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
        mq.delete(); m_ovf = 0; m_udf = 0; m_peak = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_used", 32'(used), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);

        // Fill
        push(8'h11); push(8'h22);
        chk("af_at2", 32'(almost_full), 32'd0);
        push(8'h33);
        chk("af_at3", 32'(almost_full), 32'd1);
        push(8'h44);
        chk("fill_used", 32'(used), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_head", 32'(rd_data), 32'h11);

        // Overflow, then drain
        push(8'h55);
        chk("ovf_used", 32'(used), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(rd_data), 32'(exp_seq[i]));
            pop();
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Push+pop at full
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        step(0, 0, 1, 8'h66, 1, 0);
        chk("fpp_used", 32'(used), 32'd4);
        chk("fpp_head", 32'(rd_data), 32'hA2);
        pop(); pop(); pop();
        chk("fpp_last", 32'(rd_data), 32'h66);
        pop();

        // Push+pop at empty
        step(0, 0, 1, 8'h77, 1, 0);
        chk("epp_udf", 32'(underflow), 32'd1);
        chk("epp_used", 32'(used), 32'd1);
        chk("epp_data", 32'(rd_data), 32'h77);

        // Flush with both sticky flags set, used=3
        push(8'h01); push(8'h02);
        chk("pre_clr_ovf", 32'(overflow), 32'd1);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("clr_used", 32'(used), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_udf", 32'(underflow), 32'd0);
        chk("clr_peak", 32'(peak), 32'd0);

        // err_clr alone
        pop();
        push(8'h34);
        step(0, 0, 0, 8'h00, 0, 1);
        chk("ec_udf", 32'(underflow), 32'd0);
        chk("ec_used", 32'(used), 32'd1);

        // err_clr coinciding with a new underflow: new event wins
        pop();
        step(0, 0, 0, 8'h00, 1, 1);
        chk("ec_vs_evt", 32'(underflow), 32'd1);

        // Peak scenario
        step(0, 1, 0, 8'h00, 0, 0);
        push(8'hB1); push(8'hB2); push(8'hB3);
        pop(); pop();
        push(8'hB4);
        chk("pk_used", 32'(used), 32'd2);
`ifdef FIFO_REGS_PEAK_EN
        chk("pk_peak", 32'(peak), 32'd3);
`else
        chk("pk_peak", 32'(peak), 32'd0);
`endif

        // Random run with shifting push/pop bias
        bias_w = 50; bias_r = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) begin
                bias_w = $urandom_range(90, 10);
                bias_r = $urandom_range(90, 10);
            end
            step($urandom_range(199, 0) == 0,
                 $urandom_range(59, 0) == 0,
                 $urandom_range(99, 0) < bias_w,
                 W'($urandom),
                 $urandom_range(99, 0) < bias_r,
                 $urandom_range(19, 0) == 0);
        end
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
